axis_vid_pattern_gen: RTL and testbench

//  AXI4-Stream video test-pattern source; drives one slave input of the 2:1 AXIS video switch
//  (alternative to the VDMA stream) ahead of the AXIS-to-video-out stage.

---
 rtl/axis_vid_pkg.sv | 47 ++++
 rtl/axis_vid_pat_color.sv | 30 +++
 rtl/axis_vid_pattern_gen.sv | 162 ++++++++++++++++
 tb/tb_axis_vid_pattern_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_vid_pkg.sv
// Shared types and constants for the AXI4-Stream video test-pattern generator.
package axis_vid_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_GRID  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // Pattern-space position: coordinate plus the incremental bar tracking for it.
    typedef struct packed {
        logic [11:0] px;
        logic [2:0]  bar;
        logic [11:0] cnt;
    } pxpos_t;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        unique case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/axis_vid_pat_color.sv
// Combinational pixel colour lookup for the selected test pattern.
module axis_vid_pat_color
    import axis_vid_pkg::*;
#(
    parameter int          V_ACTIVE  = 1080,
    parameter logic [23:0] SOLID_RGB = 24'h0000FF
) (
    input  pattern_e    pattern_i,
    input  logic [2:0]  bar_idx_i,
    input  logic [7:0]  px_i,
    input  logic [11:0] y_i,
    input  logic        x_last_i,
    output logic [23:0] rgb_o
);

    localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - 1);

    always_comb begin
        rgb_o = COL_BLACK;
        unique case (pattern_i)
            PAT_BARS:  rgb_o = bar_color(bar_idx_i);
            PAT_RAMP:  rgb_o = {3{px_i}};
            PAT_GRID:  rgb_o = ((px_i[4:0] == 5'd0) || (y_i[4:0] == 5'd0) || x_last_i ||
                                (y_i == Y_MAX)) ? COL_WHITE : COL_BLACK;
            PAT_SOLID: rgb_o = SOLID_RGB;
            default:   rgb_o = COL_BLACK;
        endcase
    end

endmodule

// File: rtl/axis_vid_pattern_gen.sv
// AXI4-Stream video test-pattern source, 1 pixel/beat, tuser=SOF, tlast=EOL.
// Define PAT_GEN_SCROLL_EN to scroll the pattern horizontally by one pixel per frame.
module axis_vid_pattern_gen
    import axis_vid_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          H_ACTIVE   = 1920,
    parameter int          V_ACTIVE   = 1080,
    parameter logic [23:0] SOLID_RGB  = 24'h0000FF
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    enable,
    input  logic [1:0]              pattern_sel,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tvalid,
    output logic                    frame_done
);

    localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_MAX    = 12'(V_ACTIVE - 1);
    localparam logic [11:0] BAR_W_M1 = 12'(H_ACTIVE / 8 - 1);

    state_e                  state_q;
    pattern_e                pattern_q;
    logic [11:0]             gx_q, gy_q;
    pxpos_t                  gpos_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic                    tvalid_q, tuser_q, tlast_q, flast_q, frame_done_q;
    pxpos_t                  off_q, off_d;

    logic        hs, frame_end, start, advance, load, x_last, y_last;
    logic [11:0] cur_x, cur_y;
    pxpos_t      cur_pos;
    pattern_e    cur_pat;
    logic [23:0] rgb;

    // Step one pixel in pattern space; the last bar keeps counting to absorb the remainder.
    function automatic pxpos_t px_step(input pxpos_t p);
        pxpos_t n;
        n = p;
        if (p.px == X_MAX) begin
            n = '0;
        end else begin
            n.px = p.px + 12'd1;
            if (p.cnt == BAR_W_M1 && p.bar != 3'd7) begin
                n.bar = p.bar + 3'd1;
                n.cnt = '0;
            end else begin
                n.cnt = p.cnt + 12'd1;
            end
        end
        return n;
    endfunction

    always_comb begin
        hs        = tvalid_q & m_axis_tready;
        frame_end = hs & flast_q;
        start     = enable & ((state_q == StIdle) | ((state_q == StRun) & frame_end));
        advance   = (state_q == StRun) & hs & ~flast_q;
        load      = start | advance;
        cur_x     = start ? 12'd0 : gx_q;
        cur_y     = start ? 12'd0 : gy_q;
        cur_pos   = start ? off_d : gpos_q;
        cur_pat   = start ? pattern_e'(pattern_sel) : pattern_q;
        x_last    = (cur_x == X_MAX);
        y_last    = (cur_y == Y_MAX);
    end

`ifdef PAT_GEN_SCROLL_EN
    assign off_d = frame_end ? px_step(off_q) : off_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end
`else
    assign off_q = '0;
    assign off_d = off_q;
`endif

    axis_vid_pat_color #(
        .V_ACTIVE  (V_ACTIVE),
        .SOLID_RGB (SOLID_RGB)
    ) u_color (
        .pattern_i (cur_pat),
        .bar_idx_i (cur_pos.bar),
        .px_i      (cur_pos.px[7:0]),
        .y_i       (cur_y),
        .x_last_i  (x_last),
        .rgb_o     (rgb)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            pattern_q    <= PAT_BARS;
            gx_q         <= '0;
            gy_q         <= '0;
            gpos_q       <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            flast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= {{(DATA_WIDTH - 24){1'b0}}, rgb};
                tuser_q  <= (cur_x == 12'd0) && (cur_y == 12'd0);
                tlast_q  <= x_last;
                flast_q  <= x_last & y_last;
                if (x_last) begin
                    gx_q   <= '0;
                    gy_q   <= y_last ? 12'd0 : cur_y + 12'd1;
                    gpos_q <= off_d;
                end else begin
                    gx_q   <= cur_x + 12'd1;
                    gy_q   <= cur_y;
                    gpos_q <= px_step(cur_pos);
                end
            end else if (frame_end) begin
                tvalid_q <= 1'b0;
                tuser_q  <= 1'b0;
                tlast_q  <= 1'b0;
                flast_q  <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q   <= StRun;
                        pattern_q <= pattern_e'(pattern_sel);
                    end
                end
                StRun: begin
                    if (frame_end) begin
                        if (enable) pattern_q <= pattern_e'(pattern_sel);
                        else        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_axis_vid_pattern_gen.sv
// Self-checking bench for axis_vid_pattern_gen against a coordinate-level pixel model.
module tb_axis_vid_pattern_gen;

    localparam int H = 16;
    localparam int V = 4;
    localparam int FB = H * V;
    localparam logic [23:0] BAR_COL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tuser, m_axis_tvalid, frame_done;

    always #5 aclk = ~aclk;

    axis_vid_pattern_gen #(
        .DATA_WIDTH (32),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .SOLID_RGB  (24'h0000FF)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .pattern_sel   (pattern_sel),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .frame_done    (frame_done)
    );

    int errors = 0;
    int checks = 0;
    int frame_cnt = 0;

    logic [31:0] cap_data[$];
    bit          cap_user[$];
    bit          cap_last[$];
    int          cap_cyc[$];
    int          fd_cyc[$];
    int          first_valid;
    int          stall_viol;
    bit          timed_out;

    // Expected pixel from coordinates; frame index drives the scroll offset when enabled.
    function automatic logic [31:0] ref_pix(input int pat, input int x, input int y,
                                            input int frame);
        int          off, px, bar;
        logic [23:0] c;
        logic [7:0]  r;
`ifdef PAT_GEN_SCROLL_EN
        off = frame % H;
`else
        off = 0;
`endif
        px  = (x + off) % H;
        bar = px / (H / 8);
        if (bar > 7) bar = 7;
        r = 8'(px);
        case (pat)
            0:       c = BAR_COL[bar];
            1:       c = {r, r, r};
            2:       c = ((px % 32) == 0 || (y % 32) == 0 || x == H - 1 || y == V - 1) ?
                         24'hFFFFFF : 24'h000000;
            default: c = 24'h0000FF;
        endcase
        return {8'h00, c};
    endfunction

    task automatic capture(input int nbeats, input int pct, input int tail, input int drop_at,
                           input int sel_at, input logic [1:0] sel_new);
        int          got, c, extra;
        bit          held, hu, hl;
        logic [31:0] hd;
        got = 0; c = 0; extra = 0; held = 0; hu = 0; hl = 0; hd = '0;
        cap_data.delete(); cap_user.delete(); cap_last.delete(); cap_cyc.delete();
        fd_cyc.delete();
        first_valid = -1; stall_viol = 0; timed_out = 0;
        while (1) begin
            if (got >= nbeats) begin
                if (extra >= tail) break;
                extra++;
            end
            if (c >= 2000) begin
                timed_out = 1;
                break;
            end
            @(negedge aclk);
            m_axis_tready = ($urandom_range(99) < pct);
            if (held && (!m_axis_tvalid || m_axis_tdata !== hd || m_axis_tuser !== hu ||
                         m_axis_tlast !== hl)) stall_viol++;
            if (m_axis_tvalid && first_valid < 0) first_valid = c;
            if (frame_done) fd_cyc.push_back(c);
            if (m_axis_tvalid && m_axis_tready) begin
                cap_data.push_back(m_axis_tdata);
                cap_user.push_back(m_axis_tuser);
                cap_last.push_back(m_axis_tlast);
                cap_cyc.push_back(c);
                if (cap_data.size() - 1 == drop_at) enable = 1'b0;
                if (cap_data.size() - 1 == sel_at) pattern_sel = sel_new;
                got++;
                held = 0;
            end else begin
                held = m_axis_tvalid;
                hd = m_axis_tdata; hu = m_axis_tuser; hl = m_axis_tlast;
            end
            c++;
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; enable = 1'b0; m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++;
            $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tuser !== 1'b0) begin errors++;
            $display("FAIL reset_tuser: got %b want 0", m_axis_tuser); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++;
            $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        checks++; if (frame_done !== 1'b0) begin errors++;
            $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        checks++; if (m_axis_tdata !== 32'h0) begin errors++;
            $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 4'hF) begin errors++;
            $display("FAIL reset_tkeep: got %h want f", m_axis_tkeep); end
        aresetn = 1'b1;
        frame_cnt = 0;
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++;
            $display("FAIL idle_tvalid: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_bars();
        pattern_sel = 2'd0; enable = 1'b1;
        capture(FB, 100, 3, FB - 1, -1, 2'd0);
        checks++; if (timed_out || cap_data.size() != FB) begin errors++;
            $display("FAIL bars_count: got %0d want %0d", cap_data.size(), FB); end
        checks++; if (first_valid != 0) begin errors++;
            $display("FAIL bars_latency: got %0d want 0", first_valid); end
        for (int i = 0; i < cap_data.size(); i++) begin
            checks++; if (cap_data[i] !== ref_pix(0, i % H, i / H, frame_cnt)) begin errors++;
                $display("FAIL bars_data beat %0d: got %h want %h", i, cap_data[i],
                         ref_pix(0, i % H, i / H, frame_cnt)); end
            checks++; if (cap_user[i] !== (i == 0)) begin errors++;
                $display("FAIL bars_tuser beat %0d: got %b want %b", i, cap_user[i], i == 0); end
            checks++; if (cap_last[i] !== ((i % H) == H - 1)) begin errors++;
                $display("FAIL bars_tlast beat %0d: got %b want %b", i, cap_last[i],
                         (i % H) == H - 1); end
        end
        if (cap_data.size() == FB) begin
            checks++; if (cap_data[0] !== 32'h00FFFFFF || cap_data[1] !== 32'h00FFFFFF) begin
                errors++; $display("FAIL bars_white: got %h %h want 00ffffff", cap_data[0],
                                   cap_data[1]); end
            checks++; if (cap_data[14] !== 32'h0 || cap_data[15] !== 32'h0) begin
                errors++; $display("FAIL bars_black: got %h %h want 0", cap_data[14],
                                   cap_data[15]); end
            checks++; if (fd_cyc.size() != 1 || fd_cyc[0] != cap_cyc[FB - 1] + 1) begin
                errors++; $display("FAIL bars_frame_done: got %0d pulses want 1 at cycle %0d",
                                   fd_cyc.size(), cap_cyc[FB - 1] + 1); end
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++;
            $display("FAIL bars_idle: got tvalid %b want 0", m_axis_tvalid); end
        frame_cnt += 1;
    endtask

    task automatic test_ramp_backpressure();
        pattern_sel = 2'd1; enable = 1'b1;
        capture(FB, 50, 4, 0, -1, 2'd0);
        checks++; if (timed_out || cap_data.size() != FB) begin errors++;
            $display("FAIL ramp_count: got %0d want %0d", cap_data.size(), FB); end
        for (int i = 0; i < cap_data.size(); i++) begin
            checks++; if (cap_data[i] !== ref_pix(1, i % H, i / H, frame_cnt)) begin errors++;
                $display("FAIL ramp_data beat %0d: got %h want %h", i, cap_data[i],
                         ref_pix(1, i % H, i / H, frame_cnt)); end
            checks++; if (cap_last[i] !== ((i % H) == H - 1)) begin errors++;
                $display("FAIL ramp_tlast beat %0d: got %b", i, cap_last[i]); end
        end
        checks++; if (stall_viol != 0) begin errors++;
            $display("FAIL ramp_stall_hold: got %0d violations want 0", stall_viol); end
        frame_cnt += 1;
    endtask

    task automatic test_enable_drop();
        int nuser;
        pattern_sel = 2'd3; enable = 1'b1;
        capture(FB, 100, 6, 10, -1, 2'd0);
        checks++; if (timed_out || cap_data.size() != FB) begin errors++;
            $display("FAIL drop_count: got %0d want %0d", cap_data.size(), FB); end
        nuser = 0;
        for (int i = 0; i < cap_data.size(); i++) begin
            if (cap_user[i]) nuser++;
            checks++; if (cap_data[i] !== ref_pix(3, i % H, i / H, frame_cnt)) begin errors++;
                $display("FAIL drop_data beat %0d: got %h want %h", i, cap_data[i],
                         ref_pix(3, i % H, i / H, frame_cnt)); end
        end
        checks++; if (nuser != 1) begin errors++;
            $display("FAIL drop_tuser_count: got %0d want 1", nuser); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++;
            $display("FAIL drop_idle: got tvalid %b want 0", m_axis_tvalid); end
        frame_cnt += 1;
    endtask

    task automatic test_back_to_back();
        int          pat, f;
        logic [31:0] exp;
        pattern_sel = 2'd0; enable = 1'b1;
        capture(2 * FB, 100, 3, FB, 20, 2'd2);
        checks++; if (timed_out || cap_data.size() != 2 * FB) begin errors++;
            $display("FAIL b2b_count: got %0d want %0d", cap_data.size(), 2 * FB); end
        for (int i = 0; i < cap_data.size(); i++) begin
            pat = (i < FB) ? 0 : 2;
            f = i / FB;
            exp = ref_pix(pat, i % H, (i % FB) / H, frame_cnt + f);
            checks++; if (cap_data[i] !== exp) begin errors++;
                $display("FAIL b2b_data beat %0d: got %h want %h", i, cap_data[i], exp); end
            checks++; if (cap_user[i] !== ((i % FB) == 0)) begin errors++;
                $display("FAIL b2b_tuser beat %0d: got %b", i, cap_user[i]); end
        end
        if (cap_data.size() == 2 * FB) begin
            checks++; if (cap_data[FB] !== 32'h00FFFFFF) begin errors++;
                $display("FAIL b2b_grid_first: got %h want 00ffffff", cap_data[FB]); end
            checks++; if (cap_cyc[FB] != cap_cyc[FB - 1] + 1) begin errors++;
                $display("FAIL b2b_bubble: got cycle %0d want %0d", cap_cyc[FB],
                         cap_cyc[FB - 1] + 1); end
        end
        checks++; if (fd_cyc.size() != 2) begin errors++;
            $display("FAIL b2b_frame_done: got %0d pulses want 2", fd_cyc.size()); end
        frame_cnt += 2;
    endtask

    task automatic test_mid_reset();
        pattern_sel = 2'd1; enable = 1'b1;
        capture(31, 100, 0, -1, -1, 2'd0);
        checks++; if (timed_out || cap_data.size() != 31) begin errors++;
            $display("FAIL rst_pre_count: got %0d want 31", cap_data.size()); end
        aresetn = 1'b0;
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++;
            $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
        aresetn = 1'b1;
        frame_cnt = 0;
        capture(FB, 100, 3, 0, -1, 2'd0);
        checks++; if (timed_out || cap_data.size() != FB) begin errors++;
            $display("FAIL rst_count: got %0d want %0d", cap_data.size(), FB); end
        if (cap_data.size() > 0) begin
            checks++; if (cap_user[0] !== 1'b1) begin errors++;
                $display("FAIL rst_tuser: got %b want 1", cap_user[0]); end
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            checks++; if (cap_data[i] !== ref_pix(1, i % H, i / H, frame_cnt)) begin errors++;
                $display("FAIL rst_data beat %0d: got %h want %h", i, cap_data[i],
                         ref_pix(1, i % H, i / H, frame_cnt)); end
        end
        frame_cnt += 1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge aclk);
        test_reset();
        test_bars();
        test_ramp_backpressure();
        test_enable_drop();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
